traverse_addr_gen: RTL
======================

TRAVERSE_ADDR_GEN -- requirements
Module: traverse_addr_gen

Interface
REQ-001 Parameter ADDR_W, default 16: width of all memory addresses and base/stride inputs.
REQ-002 Parameter DIM_W, default 8: width of width/height config and the x/y indices.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  launch a traversal; sampled every cycle.
REQ-006 state  input  3  accelerator phase code: 000 IDLE, 001 GET_PARAM, 010 GET_DATA, 011 EX, 100 WRIT_PRE, 101 WRITE_BACK, 110 DONE.
REQ-007 cfg_src_base  input  ADDR_W  source buffer base address.
REQ-008 cfg_dst_base  input  ADDR_W  destination buffer base address.
REQ-009 cfg_width  input  DIM_W  elements per row.
REQ-010 cfg_height  input  DIM_W  number of rows.
REQ-011 cfg_stride  input  ADDR_W  address step between rows (present only with TRAVERSE_STRIDE_EN).
REQ-012 rd_en  output  1  source memory read strobe.
REQ-013 rd_addr  output  ADDR_W  source read address.
REQ-014 wr_en  output  1  destination memory write strobe.
REQ-015 wr_addr  output  ADDR_W  destination write address.
REQ-016 cur_x  output  DIM_W  current column index.
REQ-017 cur_y  output  DIM_W  current row index.
REQ-018 busy  output  1  traversal in progress.
REQ-019 finish  output  1  one-cycle pulse: traversal complete, feeds phase controller.

Function
REQ-020 When busy=0 and start=1, the block SHALL latch all cfg_* inputs, set x=0, y=0, src_row=cfg_src_base, dst_row=cfg_dst_base, and set busy=1 on the next edge.
REQ-021 start while busy=1 SHALL be ignored; latched configuration SHALL not change mid-traversal.
REQ-022 If cfg_width=0 or cfg_height=0 at launch, busy SHALL stay 0 and finish SHALL pulse on the next cycle.
REQ-023 rd_en SHALL be combinationally 1 exactly when busy=1 and state=GET_DATA; rd_addr SHALL equal src_row + x (zero-extended), modulo 2^ADDR_W.
REQ-024 wr_en SHALL be combinationally 1 exactly when busy=1 and state=WRITE_BACK; wr_addr SHALL equal dst_row + x, modulo 2^ADDR_W.
REQ-025 rd_addr/wr_addr SHALL be valid (driven with the formula) in all states; only the strobes are gated.
REQ-026 Index advance SHALL occur only on an edge where busy=1 and state=WRITE_BACK: if x<width-1 then x<=x+1; else x<=0, y<=y+1, src_row+=row step, dst_row+=row step.
REQ-027 On WRITE_BACK with x=width-1 and y=height-1, the block SHALL clear busy and assert finish for exactly the next cycle; x, y hold their last values.
REQ-028 States IDLE, GET_PARAM, EX, WRIT_PRE, DONE and undefined codes 111 SHALL not change indices or pointers.
REQ-029 Address arithmetic SHALL wrap silently at 2^ADDR_W with no error flag.
REQ-030 finish SHALL never be asserted while busy=1.
REQ-031 cur_x/cur_y SHALL reflect the registered x/y directly.
REQ-032 Per element latency: one read in GET_DATA, one write in WRITE_BACK of the same 5-phase pass; total reads = total writes = width*height.

Reset
REQ-033 On rst_n=0 at a clock edge: busy=0, finish=0, x=0, y=0, src_row=0, dst_row=0, latched config=0; rd_en/wr_en thereby 0.
REQ-034 Reset mid-traversal SHALL abort without emitting finish; a new start is required afterwards.

Configuration
REQ-035 Macro TRAVERSE_STRIDE_EN defined: port cfg_stride exists and row step = latched cfg_stride for both source and destination.
REQ-036 Macro undefined: cfg_stride port absent; row step = latched cfg_width zero-extended to ADDR_W (dense packing).

Verification
REQ-037 width=3, height=2, src=0x0100, dst=0x0200, no macro, state cycled normally -> rd_addr 0x100..0x102,0x103..0x105; wr_addr 0x200..0x205; finish one pulse after 6th WRITE_BACK.
REQ-038 Macro on, stride=0x0010, width=2, height=2, src=0x0000 -> reads 0x0000,0x0001,0x0010,0x0011.
REQ-039 width=0, height=5, start -> busy stays 0, finish pulses next cycle, rd_en/wr_en never 1.
REQ-040 start re-pulsed with new cfg during traversal -> addresses continue from original configuration.
REQ-041 src=0xFFFE, width=4, height=1 -> rd_addr 0xFFFE,0xFFFF,0x0000,0x0001.
REQ-042 rst_n low after 2nd WRITE_BACK -> busy=0, x=y=0, no finish pulse; subsequent start restarts at base.

Source files
------------

// File: rtl/traverse_addr_gen.sv
// traverse_addr_gen
//   Walks a width x height element grid, producing one source read address
//   per GET_DATA phase and one destination write address per WRITE_BACK phase
//   of the accelerator's phase controller. Indices advance once per
//   WRITE_BACK, so each element costs one full phase pass.
//
// Build option:
//   TRAVERSE_STRIDE_EN  when defined, adds the cfg_stride port and uses it as
//                       the row step. When undefined, the row step is the
//                       latched width, which packs the rows densely.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               launch request, ignored while busy
//   state[2:0]          accelerator phase code
//   cfg_src_base/dst    buffer base addresses, latched at launch
//   cfg_width/height    grid dimensions, latched at launch
//   cfg_stride          row step (TRAVERSE_STRIDE_EN only)
//   rd_en/rd_addr       source read strobe and address
//   wr_en/wr_addr       destination write strobe and address
//   cur_x/cur_y         registered column/row index
//   busy                traversal in progress
//   finish              one-cycle completion pulse
module traverse_addr_gen #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        state,
  input  logic [ADDR_W-1:0] cfg_src_base,
  input  logic [ADDR_W-1:0] cfg_dst_base,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
`ifdef TRAVERSE_STRIDE_EN
  input  logic [ADDR_W-1:0] cfg_stride,
`endif
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DIM_W-1:0]  cur_x,
  output logic [DIM_W-1:0]  cur_y,
  output logic              busy,
  output logic              finish
);

  typedef enum logic [2:0] {
    PH_IDLE       = 3'b000,
    PH_GET_PARAM  = 3'b001,
    PH_GET_DATA   = 3'b010,
    PH_EX         = 3'b011,
    PH_WRIT_PRE   = 3'b100,
    PH_WRITE_BACK = 3'b101,
    PH_DONE       = 3'b110
  } phase_e;

  logic [DIM_W-1:0]  x_q, y_q;
  logic [DIM_W-1:0]  width_q, height_q;
  logic [ADDR_W-1:0] src_row_q, dst_row_q;
  logic [ADDR_W-1:0] row_step;
  logic              busy_q, finish_q;
  logic              is_wb, last_col, last_row;

`ifdef TRAVERSE_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;
  assign row_step = stride_q;
`else
  assign row_step = ADDR_W'(width_q);
`endif

  assign is_wb    = (state == PH_WRITE_BACK);
  assign last_col = (x_q == width_q  - DIM_W'(1));
  assign last_row = (y_q == height_q - DIM_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      finish_q  <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      src_row_q <= '0;
      dst_row_q <= '0;
      width_q   <= '0;
      height_q  <= '0;
`ifdef TRAVERSE_STRIDE_EN
      stride_q  <= '0;
`endif
    end else begin
      finish_q <= 1'b0;
      if (!busy_q) begin
        if (start) begin
          width_q   <= cfg_width;
          height_q  <= cfg_height;
`ifdef TRAVERSE_STRIDE_EN
          stride_q  <= cfg_stride;
`endif
          x_q       <= '0;
          y_q       <= '0;
          src_row_q <= cfg_src_base;
          dst_row_q <= cfg_dst_base;
          // An empty grid completes immediately without ever going busy.
          if (cfg_width == '0 || cfg_height == '0) finish_q <= 1'b1;
          else                                     busy_q   <= 1'b1;
        end
      end else if (is_wb) begin
        if (!last_col) begin
          x_q <= x_q + DIM_W'(1);
        end else if (last_row) begin
          // Final element: indices hold their last values.
          busy_q   <= 1'b0;
          finish_q <= 1'b1;
        end else begin
          x_q       <= '0;
          y_q       <= y_q + DIM_W'(1);
          src_row_q <= src_row_q + row_step;
          dst_row_q <= dst_row_q + row_step;
        end
      end
    end
  end

  // Addresses are always driven; only the strobes depend on the phase.
  assign rd_addr = src_row_q + ADDR_W'(x_q);
  assign wr_addr = dst_row_q + ADDR_W'(x_q);
  assign rd_en   = busy_q && (state == PH_GET_DATA);
  assign wr_en   = busy_q && is_wb;
  assign cur_x   = x_q;
  assign cur_y   = y_q;
  assign busy    = busy_q;
  assign finish  = finish_q;

endmodule
